// File: rtl/int_pkg.sv
// Shared definitions for the UART <-> ALU interface blocks (int_rx / int_tx).
// FSM state encodings, frame length and the default byte width live here so
// both sides of the link agree on them.
package int_pkg;

  // Default byte width of FIFO words, operands and opcode.
  localparam int DBIT_DEFAULT = 8;

  // Bytes per frame: operand A, operand B, opcode.
  localparam int FRAME_LEN = 3;

  // Receive FSM encoding.
  localparam logic [1:0] GET_A  = 2'd0;
  localparam logic [1:0] GET_B  = 2'd1;
  localparam logic [1:0] GET_OP = 2'd2;
  localparam logic [1:0] EXEC   = 2'd3;

endpackage

// File: rtl/int_rx_timer.sv
// Idle counter for int_rx. Counts cycles spent waiting inside a partial
// frame and flags expiry on the last allowed idle cycle. Only instantiated
// when INT_RX_TIMEOUT_EN is defined.
module int_rx_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_o
);

  // Width guarded so a degenerate TIMEOUT_CYCLES of 1 still gives a legal vector.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is seen in the idle cycle that would reach the limit.
  assign expire_o = inc_i && (cnt_q == LAST);

  // Next count: clear on pop / outside a partial frame / on expiry, else count idle cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/int_rx.sv
// int_rx: pops a three-byte frame (A, B, opcode) from the first-word-fall-
// through RX FIFO, holds the bytes on registered ALU inputs, and pulses
// `enviar` one cycle after the opcode lands so the TX side captures the
// settled ALU result.
// Optional feature: define INT_RX_TIMEOUT_EN to abort a partial frame after
// TIMEOUT_CYCLES idle cycles (pulsing `timeout`); otherwise it waits forever.
//
// state  | meaning
// GET_A  | waiting for / popping operand A
// GET_B  | waiting for / popping operand B
// GET_OP | waiting for / popping opcode
// EXEC   | ALU inputs complete, pulse enviar, no pop
module int_rx
  import int_pkg::*;
#(
  parameter int DBIT           = DBIT_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] data_fifo,
  output logic            RD_FIFO,
  output logic [DBIT-1:0] DATO_A,
  output logic [DBIT-1:0] DATO_B,
  output logic [DBIT-1:0] OPCODE,
  output logic            enviar,
  output logic            timeout
);

  logic [1:0]      state_q, state_d;
  logic [DBIT-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic            expire;

  // FSM next state and the combinational pop / send strobes.
  always_comb begin
    state_d = state_q;
    RD_FIFO = 1'b0;
    enviar  = 1'b0;
    case (state_q)
      GET_A: begin
        if (!fifo_empty) begin
          RD_FIFO = 1'b1;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (!fifo_empty) begin
          RD_FIFO = 1'b1;
          state_d = GET_OP;
        end else if (expire) begin
          state_d = GET_A;
        end
      end
      GET_OP: begin
        if (!fifo_empty) begin
          RD_FIFO = 1'b1;
          state_d = EXEC;
        end else if (expire) begin
          state_d = GET_A;
        end
      end
      EXEC: begin
        enviar  = 1'b1;
        state_d = GET_A;
      end
      default: state_d = GET_A;
    endcase
  end

  // Each operand register loads only on its own pop; otherwise it holds.
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    op_d = op_q;
    if (RD_FIFO) begin
      case (state_q)
        GET_A:   a_d  = data_fifo;
        GET_B:   b_d  = data_fifo;
        GET_OP:  op_d = data_fifo;
        default: ;
      endcase
    end
  end

  // State and operand registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign DATO_A = a_q;
  assign DATO_B = b_q;
  assign OPCODE = op_q;

`ifdef INT_RX_TIMEOUT_EN
  // Idle cycles only count while stuck mid-frame on an empty FIFO.
  int_rx_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .clear_i  (RD_FIFO || (state_q == GET_A) || (state_q == EXEC)),
    .inc_i    (((state_q == GET_B) || (state_q == GET_OP)) && fifo_empty),
    .expire_o (expire)
  );
  assign timeout = expire;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign expire     = 1'b0;
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_int_rx.sv
// Directed bench for int_rx. Inputs change 1 time unit after the rising
// edge, outputs are checked 1 unit later, well clear of the next edge.
module tb_int_rx;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       fifo_empty;
   logic [7:0] data_fifo;
   logic       RD_FIFO;
   logic [7:0] DATO_A, DATO_B, OPCODE;
   logic       enviar, timeout;

   int tests = 0;
   int fails = 0;

   int_rx #(
      .DBIT           (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .fifo_empty (fifo_empty),
      .data_fifo  (data_fifo),
      .RD_FIFO    (RD_FIFO),
      .DATO_A     (DATO_A),
      .DATO_B     (DATO_B),
      .OPCODE     (OPCODE),
      .enviar     (enviar),
      .timeout    (timeout)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic drv(input logic e, input logic [7:0] d);
      fifo_empty = e;
      data_fifo  = d;
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d);
      drv(1'b0, d);
      tests++;
      if (RD_FIFO !== 1'b1) begin
         fails++;
         $error("FAIL pop_strobe: observed %0h, expected %0h", RD_FIFO, 1'b1);
      end
      tests++;
      if (enviar !== 1'b0) begin
         fails++;
         $error("FAIL no_send_on_pop: observed %0h, expected %0h", enviar, 1'b0);
      end
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pops, envs, tos, both, first_env, second_env, to_idx;
      logic [7:0] spaced [3];
      logic [7:0] b2b [8];

      RESET = 1'b1;
      fifo_empty = 1'b1;
      data_fifo = 8'h00;
      #12;
      tests++;
      if (DATO_A !== 8'h00) begin
         fails++;
         $error("FAIL rst_dato_a: observed %0h, expected %0h", DATO_A, 8'h00);
      end
      tests++;
      if (DATO_B !== 8'h00) begin
         fails++;
         $error("FAIL rst_dato_b: observed %0h, expected %0h", DATO_B, 8'h00);
      end
      tests++;
      if (OPCODE !== 8'h00) begin
         fails++;
         $error("FAIL rst_opcode: observed %0h, expected %0h", OPCODE, 8'h00);
      end
      tests++;
      if (RD_FIFO !== 1'b0) begin
         fails++;
         $error("FAIL rst_rd_fifo: observed %0h, expected %0h", RD_FIFO, 1'b0);
      end
      tests++;
      if (enviar !== 1'b0) begin
         fails++;
         $error("FAIL rst_enviar: observed %0h, expected %0h", enviar, 1'b0);
      end
      tests++;
      if (timeout !== 1'b0) begin
         fails++;
         $error("FAIL rst_timeout: observed %0h, expected %0h", timeout, 1'b0);
      end
      @(negedge CLK);
      RESET = 1'b0;
      tick();

      send_byte(8'h12);
      tests++;
      if (DATO_A !== 8'h12) begin
         fails++;
         $error("FAIL mid_a_loaded: observed %0h, expected %0h", DATO_A, 8'h12);
      end
      drv(1'b1, 8'h00);
      RESET = 1'b1;
      #1;
      tests++;
      if (DATO_A !== 8'h00) begin
         fails++;
         $error("FAIL mid_rst_a_clear: observed %0h, expected %0h", DATO_A, 8'h00);
      end
      tests++;
      if (RD_FIFO !== 1'b0) begin
         fails++;
         $error("FAIL mid_rst_rd: observed %0h, expected %0h", RD_FIFO, 1'b0);
      end
      @(negedge CLK);
      RESET = 1'b0;
      tick();
      send_byte(8'h34);
      tests++;
      if (DATO_A !== 8'h34) begin
         fails++;
         $error("FAIL post_rst_a: observed %0h, expected %0h", DATO_A, 8'h34);
      end
      send_byte(8'h56);
      tests++;
      if (DATO_B !== 8'h56) begin
         fails++;
         $error("FAIL post_rst_b: observed %0h, expected %0h", DATO_B, 8'h56);
      end
      send_byte(8'h78);
      tests++;
      if (OPCODE !== 8'h78) begin
         fails++;
         $error("FAIL post_rst_op: observed %0h, expected %0h", OPCODE, 8'h78);
      end
      drv(1'b1, 8'h00);
      tests++;
      if (enviar !== 1'b1) begin
         fails++;
         $error("FAIL post_rst_enviar: observed %0h, expected %0h", enviar, 1'b1);
      end
      tick();
      tests++;
      if (enviar !== 1'b0) begin
         fails++;
         $error("FAIL post_rst_enviar_off: observed %0h, expected %0h", enviar, 1'b0);
      end

      send_byte(8'h05);
      tests++;
      if (DATO_A !== 8'h05) begin
         fails++;
         $error("FAIL cont_a: observed %0h, expected %0h", DATO_A, 8'h05);
      end
      send_byte(8'h03);
      tests++;
      if (DATO_B !== 8'h03) begin
         fails++;
         $error("FAIL cont_b: observed %0h, expected %0h", DATO_B, 8'h03);
      end
      send_byte(8'h20);
      tests++;
      if (OPCODE !== 8'h20) begin
         fails++;
         $error("FAIL cont_op: observed %0h, expected %0h", OPCODE, 8'h20);
      end
      tests++;
      if (DATO_A !== 8'h05) begin
         fails++;
         $error("FAIL cont_a_hold: observed %0h, expected %0h", DATO_A, 8'h05);
      end
      drv(1'b0, 8'h99);
      tests++;
      if (RD_FIFO !== 1'b0) begin
         fails++;
         $error("FAIL cont_exec_no_pop: observed %0h, expected %0h", RD_FIFO, 1'b0);
      end
      tests++;
      if (enviar !== 1'b1) begin
         fails++;
         $error("FAIL cont_exec_enviar: observed %0h, expected %0h", enviar, 1'b1);
      end
      tick();
      drv(1'b1, 8'h00);
      tests++;
      if (enviar !== 1'b0) begin
         fails++;
         $error("FAIL cont_enviar_once: observed %0h, expected %0h", enviar, 1'b0);
      end
      tests++;
      if (OPCODE !== 8'h20) begin
         fails++;
         $error("FAIL cont_regs_hold: observed %0h, expected %0h", OPCODE, 8'h20);
      end

      spaced[0] = 8'h11; spaced[1] = 8'h22; spaced[2] = 8'h33;
      pops = 0; envs = 0; both = 0;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 10; j++) begin
            drv(1'b1, 8'hEE);
            pops += int'(RD_FIFO);
            envs += int'(enviar);
            tick();
         end
         drv(1'b0, spaced[k]);
         pops += int'(RD_FIFO);
         envs += int'(enviar);
         tick();
      end
      for (int j = 0; j < 4; j++) begin
         drv(1'b1, 8'h00);
         pops += int'(RD_FIFO);
         envs += int'(enviar);
         both += int'(RD_FIFO && enviar);
         tick();
      end
      tests++;
      if (pops !== 3) begin
         fails++;
         $error("FAIL spaced_pops: observed %0d, expected %0d", pops, 3);
      end
      tests++;
      if (envs !== 1) begin
         fails++;
         $error("FAIL spaced_enviar: observed %0d, expected %0d", envs, 1);
      end
      tests++;
      if (DATO_A !== 8'h11) begin
         fails++;
         $error("FAIL spaced_a: observed %0h, expected %0h", DATO_A, 8'h11);
      end
      tests++;
      if (DATO_B !== 8'h22) begin
         fails++;
         $error("FAIL spaced_b: observed %0h, expected %0h", DATO_B, 8'h22);
      end
      tests++;
      if (OPCODE !== 8'h33) begin
         fails++;
         $error("FAIL spaced_op: observed %0h, expected %0h", OPCODE, 8'h33);
      end

      b2b[0] = 8'hFF; b2b[1] = 8'h01; b2b[2] = 8'h20; b2b[3] = 8'h5A;
      b2b[4] = 8'h80; b2b[5] = 8'h80; b2b[6] = 8'h22; b2b[7] = 8'h5A;
      first_env = -1; second_env = -1; pops = 0;
      for (int i = 0; i < 8; i++) begin
         drv(1'b0, b2b[i]);
         pops += int'(RD_FIFO);
         both += int'(RD_FIFO && enviar);
         if (enviar) begin
            if (first_env < 0) first_env = i;
            else second_env = i;
         end
         tick();
      end
      drv(1'b1, 8'h00);
      tests++;
      if (first_env !== 3) begin
         fails++;
         $error("FAIL b2b_first_env: observed %0d, expected %0d", first_env, 3);
      end
      tests++;
      if (second_env !== 7) begin
         fails++;
         $error("FAIL b2b_second_env: observed %0d, expected %0d", second_env, 7);
      end
      tests++;
      if (pops !== 6) begin
         fails++;
         $error("FAIL b2b_pops: observed %0d, expected %0d", pops, 6);
      end
      tests++;
      if (both !== 0) begin
         fails++;
         $error("FAIL b2b_no_pop_in_exec: observed %0d, expected %0d", both, 0);
      end
      tests++;
      if (DATO_A !== 8'h80) begin
         fails++;
         $error("FAIL b2b_a: observed %0h, expected %0h", DATO_A, 8'h80);
      end
      tests++;
      if (DATO_B !== 8'h80) begin
         fails++;
         $error("FAIL b2b_b: observed %0h, expected %0h", DATO_B, 8'h80);
      end
      tests++;
      if (OPCODE !== 8'h22) begin
         fails++;
         $error("FAIL b2b_op: observed %0h, expected %0h", OPCODE, 8'h22);
      end

      pops = 0; envs = 0; tos = 0;
      for (int i = 0; i < 1000; i++) begin
         drv(1'b1, 8'h77);
         pops += int'(RD_FIFO);
         envs += int'(enviar);
         tos  += int'(timeout);
         tick();
      end
      tests++;
      if (pops !== 0) begin
         fails++;
         $error("FAIL idle_pops: observed %0d, expected %0d", pops, 0);
      end
      tests++;
      if (envs !== 0) begin
         fails++;
         $error("FAIL idle_enviar: observed %0d, expected %0d", envs, 0);
      end
      tests++;
      if (tos !== 0) begin
         fails++;
         $error("FAIL idle_timeout: observed %0d, expected %0d", tos, 0);
      end

      send_byte(8'hAA);
      tests++;
      if (DATO_A !== 8'hAA) begin
         fails++;
         $error("FAIL to_a: observed %0h, expected %0h", DATO_A, 8'hAA);
      end
      tos = 0; to_idx = -1;
      for (int i = 0; i < 16; i++) begin
         drv(1'b1, 8'h00);
         tos += int'(timeout);
         both += int'(timeout && RD_FIFO);
         if (timeout) to_idx = i;
         tick();
      end
`ifdef INT_RX_TIMEOUT_EN
      tests++;
      if (tos !== 1) begin
         fails++;
         $error("FAIL to_pulses: observed %0d, expected %0d", tos, 1);
      end
      tests++;
      if (to_idx !== 15) begin
         fails++;
         $error("FAIL to_cycle: observed %0d, expected %0d", to_idx, 15);
      end
      tests++;
      if (DATO_A !== 8'hAA) begin
         fails++;
         $error("FAIL to_regs_kept: observed %0h, expected %0h", DATO_A, 8'hAA);
      end
      send_byte(8'h01);
      tests++;
      if (DATO_A !== 8'h01) begin
         fails++;
         $error("FAIL to_next_a: observed %0h, expected %0h", DATO_A, 8'h01);
      end
      send_byte(8'h02);
      tests++;
      if (DATO_B !== 8'h02) begin
         fails++;
         $error("FAIL to_next_b: observed %0h, expected %0h", DATO_B, 8'h02);
      end
      send_byte(8'h20);
      tests++;
      if (OPCODE !== 8'h20) begin
         fails++;
         $error("FAIL to_next_op: observed %0h, expected %0h", OPCODE, 8'h20);
      end
`else
      tests++;
      if (tos !== 0) begin
         fails++;
         $error("FAIL to_pulses: observed %0d, expected %0d", tos, 0);
      end
      tests++;
      if (to_idx !== -1) begin
         fails++;
         $error("FAIL to_cycle: observed %0d, expected %0d", to_idx, -1);
      end
      send_byte(8'h01);
      tests++;
      if (DATO_B !== 8'h01) begin
         fails++;
         $error("FAIL wait_b: observed %0h, expected %0h", DATO_B, 8'h01);
      end
      tests++;
      if (DATO_A !== 8'hAA) begin
         fails++;
         $error("FAIL wait_a_kept: observed %0h, expected %0h", DATO_A, 8'hAA);
      end
      send_byte(8'h02);
      tests++;
      if (OPCODE !== 8'h02) begin
         fails++;
         $error("FAIL wait_op: observed %0h, expected %0h", OPCODE, 8'h02);
      end
`endif
      drv(1'b1, 8'h00);
      tests++;
      if (enviar !== 1'b1) begin
         fails++;
         $error("FAIL to_frame_enviar: observed %0h, expected %0h", enviar, 1'b1);
      end
      tests++;
      if (timeout !== 1'b0) begin
         fails++;
         $error("FAIL to_frame_no_timeout: observed %0h, expected %0h", timeout, 1'b0);
      end
      tick();
      tests++;
      if (both !== 0) begin
         fails++;
         $error("FAIL never_pop_with_send_or_timeout: observed %0d, expected %0d", both, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
